// File: rtl/prog_loader_mem.sv
// prog_loader_mem
// Program memory with a built-in byte-stream loader. After clr it fills the
// DEPTH x DATA_W array from a valid/ready byte stream while holding the CPU in
// reset. It then keeps the CPU in reset for RESET_HOLD more cycles, releases
// it, and serves the CPU's read/write port.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   load_valid   load byte present
//   load_data    load byte
//   load_last    marks the final byte of the program
//   load_ready   loader accepts a byte this cycle (registered)
//   cpu_clr      reset to the CPU (registered)
//   cpu_read     CPU read strobe (reads are always enabled, so it is not used)
//   cpu_write    CPU write strobe (honoured only in RUN)
//   cpu_address  CPU word address
//   cpu_wdata    CPU write data
//   cpu_rdata    asynchronous read data, forced to 0 unless running
//   done         loading finished and CPU released (registered)
//   load_err     sticky: load_valid seen after loading ended (registered)
module prog_loader_mem #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RESET_HOLD = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_clr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              done,
    output logic              load_err
);

    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              load_ready_r;
    logic              cpu_clr_r;
    logic              done_r;
    logic              load_err_r;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              err_set_s;
    logic              unused_cpu_read_s;

    assign unused_cpu_read_s = cpu_read;

    // Next-state, write-port selection and error detection
    always_comb begin
        state_next_s    = state_r;
        wr_ptr_next_s   = wr_ptr_r;
        hold_cnt_next_s = hold_cnt_r;
        mem_we_s        = 1'b0;
        mem_waddr_s     = wr_ptr_r;
        mem_wdata_s     = load_data;
        err_set_s       = 1'b0;
        case (state_r)
            ST_LOAD: begin
                // load_ready_r is registered, so acceptance never depends
                // combinationally on load_valid reaching load_ready.
                if (load_valid && load_ready_r) begin
                    mem_we_s = 1'b1;
                    // The pointer saturates at the last word; a full array
                    // ends the load even without load_last.
                    if (wr_ptr_r != LAST_ADDR) begin
                        wr_ptr_next_s = wr_ptr_r + ADDR_W'(1);
                    end else begin
                        wr_ptr_next_s = wr_ptr_r;
                    end
                    if (load_last || (wr_ptr_r == LAST_ADDR)) begin
                        state_next_s    = ST_HOLD;
                        hold_cnt_next_s = HOLD_INIT;
                    end else begin
                        state_next_s    = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                err_set_s = load_valid;
                if (hold_cnt_r == '0) begin
                    state_next_s = ST_RUN;
                end else begin
                    hold_cnt_next_s = hold_cnt_r - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                err_set_s = load_valid;
                if (cpu_write) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cpu_address;
                    mem_wdata_s = cpu_wdata;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // State, counters, memory array and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= ST_LOAD;
            wr_ptr_r     <= '0;
            hold_cnt_r   <= '0;
            load_ready_r <= 1'b0;
            cpu_clr_r    <= 1'b1;
            done_r       <= 1'b0;
            load_err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            state_r      <= state_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            hold_cnt_r   <= hold_cnt_next_s;
            load_ready_r <= (state_next_s == ST_LOAD);
            cpu_clr_r    <= (state_next_s != ST_RUN);
            done_r       <= (state_next_s == ST_RUN);
            load_err_r   <= load_err_r | err_set_s;
            if (mem_we_s) begin
                mem_r[mem_waddr_s] <= mem_wdata_s;
            end
        end
    end

    assign load_ready = load_ready_r;
    assign cpu_clr    = cpu_clr_r;
    assign done       = done_r;
    assign load_err   = load_err_r;
    // Reads are asynchronous; the CPU sees zeros while loading, holding or in
    // a reset cycle.
    assign cpu_rdata  = (done_r && !clr) ? mem_r[cpu_address] : '0;

endmodule

// File: tb/tb_prog_loader_mem.sv
module tb_prog_loader_mem;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       cpu_read = 1'b0;
    logic       cpu_write = 1'b0;
    logic [3:0] cpu_address = 4'd0;
    logic [7:0] cpu_wdata = 8'h00;

    logic       load_ready, cpu_clr, done, load_err;
    logic [7:0] cpu_rdata;
    logic       h1_load_ready, h1_cpu_clr, h1_done, h1_load_err;
    logic [7:0] h1_cpu_rdata;

    prog_loader_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RESET_HOLD(2)) dut (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .cpu_clr(cpu_clr),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .done(done), .load_err(load_err)
    );

    prog_loader_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RESET_HOLD(1)) dut_h1 (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(h1_load_ready), .cpu_clr(h1_cpu_clr),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_rdata(h1_cpu_rdata), .done(h1_done), .load_err(h1_load_err)
    );

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t       vt [9];
    int         errors = 0;
    int         checks = 0;

    // Reference model: memory image plus loader bookkeeping
    logic [7:0] model_mem [16];
    logic [7:0] stream [32];
    bit         exp_ready;
    bit         exp_err;
    int         wp;
    int         n_acc;
    int         first_acc;
    int         last_acc;
    int         cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
        cpu_write = 1'b0; cpu_read = 1'b0; cpu_address = 4'd0; cpu_wdata = 8'h00;
        #1;
        chk("rdata_in_clr_cycle", cpu_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_cpu_clr", cpu_clr, 1);
        chk("rst_done", done, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_h1_cpu_clr", h1_cpu_clr, 1);
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        exp_ready = 1'b1; exp_err = 1'b0; wp = 0; n_acc = 0; cyc = 0;
        first_acc = 0; last_acc = 0;
    endtask

    // Offer stream[0..n-1]; after loading ends remaining bytes are offered once each.
    task automatic send(input int n, input bit use_last, input bit stall);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 1000) begin
            guard++;
            load_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = stream[i];
            load_last  = use_last && (i == n - 1);
            #1;
            chk("load_ready", load_ready, exp_ready);
            chk("h1_load_ready", h1_load_ready, exp_ready);
            acc = load_valid && exp_ready;
            @(posedge clk);
            cyc++;
            if (acc) begin
                model_mem[wp] = load_data;
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                if (load_last || wp == 15) exp_ready = 1'b0;
                wp++;
                i++;
            end else if (!exp_ready) begin
                if (load_valid) exp_err = 1'b1;
                i++;
            end
            @(negedge clk);
        end
        if (guard >= 1000) begin
            checks++; errors++;
            $display("FAIL send_timeout: got %0d bytes of %0d", i, n);
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("load_err", load_err, exp_err);
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic readback(input string name);
        for (int a = 0; a < 16; a++) begin
            cpu_address = 4'(a);
            #1;
            chk(name, cpu_rdata, model_mem[a]);
            @(negedge clk);
        end
    endtask

    task automatic cpu_write_in_load();
        for (int k = 0; k < 2; k++) begin
            cpu_write = 1'b1; cpu_address = 4'd5; cpu_wdata = 8'hA5;
            #1;
            chk("load_phase_rdata", cpu_rdata, 0);
            @(posedge clk);
            @(negedge clk);
        end
        cpu_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 4'd6, 8'h00, 8'h02};
        vt[1] = '{1'b0, 4'd7, 8'h00, 8'h03};
        vt[2] = '{1'b0, 4'd8, 8'h00, 8'h00};
        vt[3] = '{1'b0, 4'd0, 8'h00, 8'h17};
        vt[4] = '{1'b1, 4'd5, 8'hA5, 8'h00};
        vt[5] = '{1'b0, 4'd5, 8'h00, 8'hA5};
        vt[6] = '{1'b1, 4'd3, 8'h3C, 8'h00};
        vt[7] = '{1'b0, 4'd3, 8'h00, 8'h3C};
        vt[8] = '{1'b0, 4'd2, 8'h00, 8'h54};

        // Full load with load_last on the 8th byte
        do_reset();
        stream[0] = 8'h17; stream[1] = 8'h54; stream[2] = 8'h54; stream[3] = 8'h00;
        stream[4] = 8'h00; stream[5] = 8'h00; stream[6] = 8'h02; stream[7] = 8'h03;
        send(8, 1'b1, 1'b0);
        chk("accept_count", n_acc, 8);
        chk("accept_span", last_acc - first_acc + 1, 8);
        for (int j = 0; j <= 3; j++) begin
            if (j > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            cpu_address = 4'd0;
            #1;
            chk("cpu_clr_rh2", cpu_clr, (j < 2));
            chk("done_rh2", done, (j >= 2));
            chk("cpu_clr_rh1", h1_cpu_clr, (j < 1));
            chk("done_rh1", h1_done, (j >= 1));
            chk("rdata_gate", cpu_rdata, (j >= 2) ? 32'h17 : 32'h0);
            chk("ready_after_load", load_ready, 0);
        end
        @(negedge clk);

        // Table of CPU reads/writes in RUN
        for (int t = 0; t < 9; t++) begin
            cpu_write = vt[t].wr; cpu_address = vt[t].addr; cpu_wdata = vt[t].wdata;
            #1;
            chk("table_rdata", cpu_rdata, vt[t].exp);
            @(posedge clk);
            if (vt[t].wr) model_mem[vt[t].addr] = vt[t].wdata;
            @(negedge clk);
        end
        cpu_write = 1'b0;
        readback("full_load_mem");

        // Overrun: 20 bytes, no load_last
        do_reset();
        for (int i = 0; i < 20; i++) stream[i] = 8'(i + 1);
        send(20, 1'b0, 1'b0);
        chk("overrun_accepts", n_acc, 16);
        chk("overrun_err", load_err, 1);
        wait_cycles(2);
        cpu_address = 4'd15;
        #1;
        chk("overrun_mem15", cpu_rdata, 8'h10);
        @(negedge clk);
        readback("overrun_mem");
        chk("overrun_err_sticky", load_err, 1);

        // Mid-load reset after 3 bytes, CPU write during LOAD, fresh 2-byte load
        do_reset();
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
        send(3, 1'b0, 1'b0);
        chk("midload_cpu_clr", cpu_clr, 1);
        do_reset();
        cpu_write_in_load();
        stream[0] = 8'h44; stream[1] = 8'h55;
        send(2, 1'b1, 1'b0);
        wait_cycles(3);
        chk("fresh_done", done, 1);
        readback("fresh_mem");

        // Randomised stalled streams plus random CPU traffic
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) stream[i] = 8'($urandom);
            send(n, 1'b1, 1'b1);
            chk("stall_accepts", n_acc, n);
            wait_cycles(3);
            readback("stall_mem");
            for (int k = 0; k < 20; k++) begin
                cpu_read    = 1'($urandom_range(0, 1));
                cpu_write   = 1'($urandom_range(0, 1));
                cpu_address = 4'($urandom);
                cpu_wdata   = 8'($urandom);
                #1;
                chk("rand_rdata", cpu_rdata, model_mem[cpu_address]);
                @(posedge clk);
                if (cpu_write) model_mem[cpu_address] = cpu_wdata;
                @(negedge clk);
            end
            cpu_write = 1'b0;
            readback("rand_mem");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader_mem.md
# prog_loader_mem

Program memory with an integrated byte-stream loader, sitting directly below the CPU on its memory port. After reset it fills its DEPTH×DATA_W array from a valid/ready byte stream while holding the CPU in reset. It then releases the CPU and serves the CPU's read/write port, replacing the bench-level memory array. Programs are supplied as a byte stream, for example from a UART receiver or a host bench, with no hierarchical preloading.

## Interface
- DATA_W, 8, word width (matches the CPU data bus)
- ADDR_W, 4, address width
- DEPTH, 16, number of words; must equal 2**ADDR_W
- RESET_HOLD, 2, cycles the CPU is kept in reset after loading completes; must be ≥1
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, synchronous, active-high
- load_valid  in  1  a load byte is present
- load_data  in  DATA_W  load byte
- load_last  in  1  qualifies load_data as the final byte of the program
- load_ready  out  1  loader accepts a byte this cycle
- cpu_clr  out  1  reset driven to the CPU's clr input
- cpu_read  in  1  CPU read strobe; informational only, reads are always enabled
- cpu_write  in  1  CPU write strobe
- cpu_address  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data (the CPU's memoryIn)
- cpu_rdata  out  DATA_W  read data to the CPU (the CPU's memoryOut)
- done  out  1  loading finished and the CPU is running
- load_err  out  1  sticky flag: load_valid was seen outside LOAD

## Operation
- The FSM has three states: LOAD, HOLD and RUN.
- **Reset.** While clr=1 at a rising edge:
  - state goes to LOAD, wr_ptr to 0 and hold_cnt to 0;
  - all DEPTH words are cleared to 0;
  - load_err goes to 0.
- **Output values in reset.** During a reset cycle and the cycle after it: load_ready=0, cpu_clr=1, done=0, cpu_rdata=0. All outputs are registered except cpu_rdata.
- **LOAD.**
  - load_ready=1 from the first cycle after clr is released.
  - A byte is accepted on an edge where load_valid && load_ready. At that edge mem[wr_ptr] is written with load_data and wr_ptr increments.
  - Loading stops on acceptance of a byte with load_last=1, or on acceptance of the byte at wr_ptr=DEPTH-1. The FSM then moves to HOLD, hold_cnt is set to RESET_HOLD-1, and load_ready drops.
  - Words that are never loaded keep the value 0.
  - cpu_write is ignored; cpu_rdata=0.
- **HOLD.**
  - load_ready=0 and cpu_clr=1.
  - hold_cnt decrements each cycle. The cycle in which it reads 0 moves the FSM to RUN.
- **RUN.**
  - cpu_clr=0, done=1, load_ready=0.
  - cpu_rdata = mem[cpu_address] as a combinational (asynchronous) read.
  - When cpu_write=1 at an edge, mem[cpu_address] is written with cpu_wdata.
- **load_err.** load_valid=1 in HOLD or RUN sets load_err; it stays set until clr.
- **Reset mid-operation.** clr in any state returns the block to LOAD with the memory cleared. Partial loads are discarded and the CPU is held in reset again from the cycle after the clr edge.
- **Address wrap.** wr_ptr never wraps. Reaching DEPTH words ends the load even if load_last was never asserted.

## Timing
- Load throughput is one byte per cycle while load_valid stays high.
- cpu_clr release: if the final byte is accepted at edge k, cpu_clr and done change at edge k+RESET_HOLD. cpu_clr is therefore high for exactly RESET_HOLD cycles after the final accept.
- Read latency is 0 cycles: cpu_rdata follows cpu_address in the same cycle.
- A CPU write at edge n is visible on cpu_rdata from cycle n+1.
- If the CPU reads and writes the same address in one cycle, cpu_rdata returns the old value until the edge.
- During LOAD, load_ready has no combinational path from load_valid.

## Test plan
- **Full load.** Send 00010111, 01010100, 01010100, then 00000000 ×3, then 00000010, 00000011, with load_last on the 8th byte and RESET_HOLD=2.
  - Expect 8 accepts in 8 cycles.
  - Expect cpu_clr to fall exactly 2 cycles after the last accept.
  - In RUN, expect address 6 → 0x02, address 7 → 0x03, address 8 → 0x00.
- **Overrun.** Send 20 bytes 0x01..0x14 with no load_last.
  - Expect load_ready to drop after byte 0x10 is stored at address 15.
  - Expect load_err=1 once load_valid stays high in HOLD.
  - Expect mem[15]=0x10.
- **Stalled stream.** Toggle load_valid randomly.
  - Only cycles with valid&&ready advance wr_ptr.
  - Expect memory contents to equal the sent sequence.
- **CPU write in RUN.**
  - cpu_write=1, cpu_address=5, cpu_wdata=0xA5 → cpu_rdata=0xA5 at address 5 the next cycle.
  - The same write attempted during LOAD has no effect (mem[5] stays 0).
- **Mid-load reset.**
  - Pulse clr after 3 bytes → memory reads all 0 and cpu_clr=1.
  - A fresh 2-byte load then completes normally.
- **RESET_HOLD=1 build.** Expect cpu_clr to fall at the edge immediately after the final accept.
